// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing data_mem between the I-cache (p0) and D-cache (p1): line refills and single stores.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise p1 has fixed priority.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = 4,
    localparam int IdxW      = $clog2(LINE_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [XLEN-1:0] p0_addr,
    input  logic [XLEN-1:0] p0_wdata,
    input  logic [2:0]      p0_funct3,
    output logic            p0_gnt,
    output logic            p0_rvalid,
    output logic [XLEN-1:0] p0_rdata,
    output logic [IdxW-1:0] p0_ridx,
    output logic            p0_done,

    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    input  logic [2:0]      p1_funct3,
    output logic            p1_gnt,
    output logic            p1_rvalid,
    output logic [XLEN-1:0] p1_rdata,
    output logic [IdxW-1:0] p1_ridx,
    output logic            p1_done,

    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    output logic [2:0]      mem_ctrl,
    input  logic [XLEN-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(LINE_WORDS - 1);
    localparam logic [XLEN-1:0] LineMask = XLEN'(LINE_WORDS * 4 - 1);

    state_t                      state_q, state_d;
    logic [IdxW-1:0]             count_q, count_d;
    logic                        owner_q, owner_d;
    logic [XLEN-1:0]             addr_q, addr_d;
    logic [XLEN-1:0]             wdata_q, wdata_d;
    logic [2:0]                  funct3_q, funct3_d;

    logic [1:0]                  gnt_q, gnt_d;
    logic [1:0]                  rvalid_q, rvalid_d;
    logic [1:0]                  done_q, done_d;
    logic [1:0][XLEN-1:0]        rdata_q, rdata_d;
    logic [1:0][IdxW-1:0]        ridx_q, ridx_d;

    logic [1:0]                  req;
    logic                        winner;
    logic                        selWe;
    logic [XLEN-1:0]             selAddr;
    logic [XLEN-1:0]             selWdata;
    logic [2:0]                  selFunct3;
    logic [XLEN-1:0]             lineBase;

    assign req = {p1_req, p0_req};

`ifdef ARB_ROUND_ROBIN_EN
    logic lastGrant_q, lastGrant_d;

    // On a tie, the port that was not granted most recently wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~lastGrant_q;
        end else begin
            winner = req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

    always_comb begin
        lastGrant_d = lastGrant_q;
        if (state_q == IDLE && req != 2'b00) begin
            lastGrant_d = winner;
        end
    end
`else
    assign winner = req[1];
`endif

    assign selWe     = winner ? p1_we     : p0_we;
    assign selAddr   = winner ? p1_addr   : p0_addr;
    assign selWdata  = winner ? p1_wdata  : p0_wdata;
    assign selFunct3 = winner ? p1_funct3 : p0_funct3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            ridx_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            ridx_q   <= ridx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        gnt_d    = '0;
        rvalid_d = '0;
        done_d   = '0;
        rdata_d  = rdata_q;
        ridx_d   = ridx_q;

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d        = winner;
                    gnt_d[winner]  = 1'b1;
                    count_d        = '0;
                    addr_d         = selAddr;
                    wdata_d        = selWdata;
                    funct3_d       = selFunct3;
                    state_d        = selWe ? WRITE : READ;
                end
            end
            // Each beat's data is registered, so the word addressed now appears on rdata next cycle.
            READ: begin
                rvalid_d[owner_q] = 1'b1;
                rdata_d[owner_q]  = mem_rd;
                ridx_d[owner_q]   = count_q;
                count_d           = count_q + 1'b1;
                if (count_q == LastIdx) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            WRITE: begin
                done_d[owner_q] = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lineBase = addr_q & ~LineMask;

    always_comb begin
        mem_we   = 1'b0;
        mem_a    = '0;
        mem_wd   = '0;
        mem_ctrl = 3'b000;
        unique case (state_q)
            READ: begin
                mem_a    = lineBase + (XLEN'(count_q) << 2);
                mem_ctrl = 3'b010;
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_a    = addr_q;
                mem_wd   = wdata_q;
                mem_ctrl = funct3_q;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign p0_gnt    = gnt_q[0];
    assign p0_rvalid = rvalid_q[0];
    assign p0_rdata  = rdata_q[0];
    assign p0_ridx   = ridx_q[0];
    assign p0_done   = done_q[0];

    assign p1_gnt    = gnt_q[1];
    assign p1_rvalid = rvalid_q[1];
    assign p1_rdata  = rdata_q[1];
    assign p1_ridx   = ridx_q[1];
    assign p1_done   = done_q[1];

endmodule
